// File: rtl/spi_rx_trig_gen2.sv
// Passive SPI receive trigger: snoops SS_n/SCLK/MOSI, assembles a frame and pulses SPItrig on match.
// Optional trigger counter enabled by defining SPI_RX_TRIG_CNT_EN.
module spi_rx_trig_gen2 #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 3,
    parameter int LEN_W       = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              SCLK,
    input  logic              MOSI,
    input  logic              edg,
    input  logic              lsb_first,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] mask,
    input  logic [DATA_W-1:0] match,
    output logic              SPItrig,
    output logic              rx_vld,
    output logic [DATA_W-1:0] rx_data,
    output logic              frame_err
`ifdef SPI_RX_TRIG_CNT_EN
    ,
    input  logic              trig_cnt_clr,
    output logic [15:0]       trig_cnt
`endif
);

    // One extra count bit so the saturation value DATA_W+1 is always representable
    localparam int                CNT_W    = LEN_W + 1;
    localparam logic [LEN_W-1:0]  DATA_W_L = LEN_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] ss_sync_r;
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   ss_s;
    logic                   mosi_s;
    logic                   strobe_s;

    state_t                 state_r, state_nxt_s;
    logic [DATA_W-1:0]      shift_r, shift_nxt_s;
    logic [CNT_W-1:0]       bit_cnt_r, cnt_nxt_s;
    logic [LEN_W-1:0]       len_eff_s;
    logic [CNT_W-1:0]       shamt_s;
    logic [DATA_W-1:0]      len_mask_s;
    logic [DATA_W-1:0]      word_s;
    logic                   ok_s;
    logic                   hit_s;

    logic                   vld_r, vld_nxt_s;
    logic                   err_r, err_nxt_s;
    logic                   trig_r, trig_nxt_s;
    logic [DATA_W-1:0]      data_r, data_nxt_s;

    // SS_n synchroniser, idles deasserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            ss_sync_r <= {ss_sync_r[SYNC_STAGES-2:0], SS_n};
        end
    end

    // SCLK and MOSI synchronisers share depth so MOSI stays aligned to the clock edge
    always_ff @(posedge clk) begin
        sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], SCLK};
        mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
    end

    assign ss_s     = ss_sync_r[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_r[SYNC_STAGES-1];
    assign strobe_s = edg ? (sclk_sync_r[SYNC_STAGES-2] & ~sclk_sync_r[SYNC_STAGES-1])
                          : (~sclk_sync_r[SYNC_STAGES-2] & sclk_sync_r[SYNC_STAGES-1]);

    assign len_eff_s  = ((len == {LEN_W{1'b0}}) || (len > DATA_W_L)) ? DATA_W_L : len;
    assign shamt_s    = CNT_W'(DATA_W) - {1'b0, len_eff_s};
    assign len_mask_s = ~({DATA_W{1'b1}} << len_eff_s);
    assign ok_s       = (bit_cnt_r == {1'b0, len_eff_s});
    assign hit_s      = &(~(word_s ^ match) | mask | ~len_mask_s);

    // LSB-first frames land at the top of the register and must be right-aligned
    always_comb begin
        word_s = shift_r;
        if (lsb_first) begin
            word_s = (shift_r >> shamt_s) & len_mask_s;
        end else begin
            word_s = shift_r & len_mask_s;
        end
    end

    // Frame FSM next-state and datapath updates
    always_comb begin
        state_nxt_s = state_r;
        shift_nxt_s = shift_r;
        cnt_nxt_s   = bit_cnt_r;
        vld_nxt_s   = 1'b0;
        err_nxt_s   = 1'b0;
        trig_nxt_s  = 1'b0;
        data_nxt_s  = data_r;
        case (state_r)
            IDLE: begin
                if (!ss_s) begin
                    state_nxt_s = SHIFT;
                    shift_nxt_s = {DATA_W{1'b0}};
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (strobe_s) begin
                    if (lsb_first) begin
                        shift_nxt_s = {mosi_s, shift_r[DATA_W-1:1]};
                    end else begin
                        shift_nxt_s = {shift_r[DATA_W-2:0], mosi_s};
                    end
                    if (bit_cnt_r != CNT_MAX) begin
                        cnt_nxt_s = bit_cnt_r + CNT_W'(1);
                    end else begin
                        cnt_nxt_s = bit_cnt_r;
                    end
                end else begin
                    shift_nxt_s = shift_r;
                end
                if (ss_s) begin
                    state_nxt_s = CHECK;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            CHECK: begin
                vld_nxt_s   = 1'b1;
                err_nxt_s   = ~ok_s;
                trig_nxt_s  = ok_s & hit_s;
                data_nxt_s  = word_s;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            shift_r   <= {DATA_W{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
            vld_r     <= 1'b0;
            err_r     <= 1'b0;
            trig_r    <= 1'b0;
            data_r    <= {DATA_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            shift_r   <= shift_nxt_s;
            bit_cnt_r <= cnt_nxt_s;
            vld_r     <= vld_nxt_s;
            err_r     <= err_nxt_s;
            trig_r    <= trig_nxt_s;
            data_r    <= data_nxt_s;
        end
    end

    assign SPItrig   = trig_r;
    assign rx_vld    = vld_r;
    assign rx_data   = data_r;
    assign frame_err = err_r;

`ifdef SPI_RX_TRIG_CNT_EN
    logic [15:0] trig_cnt_r;

    // Saturating trigger counter; clear beats a simultaneous increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_cnt_r <= 16'h0000;
        end else if (trig_cnt_clr) begin
            trig_cnt_r <= 16'h0000;
        end else if (trig_r && (trig_cnt_r != 16'hFFFF)) begin
            trig_cnt_r <= trig_cnt_r + 16'h0001;
        end else begin
            trig_cnt_r <= trig_cnt_r;
        end
    end

    assign trig_cnt = trig_cnt_r;
`else
    // No trigger counter in this build
`endif

endmodule

// File: tb/tb_spi_rx_trig_gen2.sv
// Self-checking bench for spi_rx_trig_gen2: directed vector table, corner sequences and
// randomized frames checked against a transmit-order reference model.
module tb_spi_rx_trig_gen2;

    localparam int DW = 32;
    localparam int SS = 3;
    localparam int LW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          SS_n = 1'b1;
    logic          SCLK = 1'b0;
    logic          MOSI = 1'b0;
    logic          edg = 1'b1;
    logic          lsb_first = 1'b0;
    logic [LW-1:0] len = 6'd8;
    logic [DW-1:0] mask = 32'h0;
    logic [DW-1:0] match = 32'h0;
    logic          SPItrig;
    logic          rx_vld;
    logic [DW-1:0] rx_data;
    logic          frame_err;
`ifdef SPI_RX_TRIG_CNT_EN
    logic          trig_cnt_clr = 1'b0;
    logic [15:0]   trig_cnt;
`endif

    spi_rx_trig_gen2 #(.DATA_W(DW), .SYNC_STAGES(SS), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .edg(edg), .lsb_first(lsb_first), .len(len), .mask(mask), .match(match),
        .SPItrig(SPItrig), .rx_vld(rx_vld), .rx_data(rx_data), .frame_err(frame_err)
`ifdef SPI_RX_TRIG_CNT_EN
        , .trig_cnt_clr(trig_cnt_clr), .trig_cnt(trig_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
        logic          t;
        int            c;
    } res_t;
    res_t resq[$];
    logic prev_vld = 1'b0;
    int   long_pulse = 0;
    int   stray = 0;
    int   vld_count = 0;

    // Capture every completed frame and police pulse shapes
    always @(negedge clk) begin
        if (rx_vld) begin
            resq.push_back('{rx_data, frame_err, SPItrig, cyc});
            vld_count <= vld_count + 1;
        end
        if (rx_vld && prev_vld) long_pulse <= long_pulse + 1;
        if (!rx_vld && (SPItrig || frame_err)) stray <= stray + 1;
        prev_vld <= rx_vld;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, required earlier finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: word bit i is the transmitted bit whose position follows from bit order and length
    function automatic void model_frame(input logic l, input int ln, input int n, input logic [63:0] d,
                                        input logic [31:0] mt, input logic [31:0] mk,
                                        output logic [31:0] xd, output logic xe, output logic xt);
        logic tx[64];
        int   le;
        int   idx;
        for (int k = 0; k < 64; k++) tx[k] = 1'b0;
        for (int k = 0; k < n; k++) tx[k] = l ? d[k] : d[n-1-k];
        le = (ln == 0 || ln > DW) ? DW : ln;
        xd = 32'h0;
        xt = 1'b1;
        for (int i = 0; i < le; i++) begin
            idx = l ? (n - le + i) : (n - 1 - i);
            if (idx >= 0 && idx < n) xd[i] = tx[idx];
            if (!mk[i] && (xd[i] != mt[i])) xt = 1'b0;
        end
        xe = (n != le);
        if (xe) xt = 1'b0;
    endfunction

    task automatic setup(input logic e, input logic l, input logic [LW-1:0] ln,
                         input logic [31:0] mt, input logic [31:0] mk);
        @(negedge clk);
        edg = e; lsb_first = l; len = ln; match = mt; mask = mk;
        SCLK = ~e;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_bits(input logic l, input logic [63:0] d, input int n);
        @(negedge clk);
        SS_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            MOSI = l ? d[k] : d[n-1-k];
            repeat (4) @(negedge clk);
            SCLK = edg;
            repeat (4) @(negedge clk);
            SCLK = ~edg;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic end_frame(output int rise);
        SS_n = 1'b1;
        rise = cyc;
    endtask

    task automatic check_result(input string nm, input int rise, input logic [31:0] xd,
                                input logic xe, input logic xt);
        int   w;
        res_t r;
        w = 0;
        while (resq.size() == 0 && w < 60) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (resq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s timeout: got no rx_vld, expected one", nm);
        end else begin
            r = resq.pop_front();
            chk({nm, " data"}, r.d, xd);
            chk({nm, " err"}, 32'(r.e), 32'(xe));
            chk({nm, " trig"}, 32'(r.t), 32'(xt));
            chk({nm, " latency"}, 32'(r.c - rise), 32'(SS + 2));
        end
    endtask

    task automatic run_frame(input string nm, input logic e, input logic l, input logic [LW-1:0] ln,
                             input int n, input logic [63:0] d, input logic [31:0] mt,
                             input logic [31:0] mk, input logic [31:0] xd, input logic xe,
                             input logic xt);
        int rise;
        setup(e, l, ln, mt, mk);
        send_bits(l, d, n);
        end_frame(rise);
        check_result(nm, rise, xd, xe, xt);
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        logic          e;
        logic          l;
        logic [LW-1:0] ln;
        int            n;
        logic [63:0]   d;
        logic [31:0]   mt;
        logic [31:0]   mk;
        logic [31:0]   xd;
        logic          xe;
        logic          xt;
    } vec_t;
    vec_t tbl[15];

    initial begin
        logic [31:0] xd, mt, mk;
        logic        xe, xt, l, e;
        logic [63:0] d;
        int          ln, le, n, sel, r1, r2, v0;

        tbl[0]  = '{1'b1, 1'b0, 6'd8,  8,  64'hA5,          32'hA5,       32'h0,        32'hA5,       1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 6'd8,  8,  64'hA4,          32'hA5,       32'h0,        32'hA4,       1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 6'd8,  8,  64'hA4,          32'hA5,       32'h01,       32'hA4,       1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 6'd16, 16, 64'h1234,        32'h1234,     32'h0,        32'h1234,     1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 6'd8,  7,  64'h25,          32'hA5,       32'h0,        32'h25,       1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 6'd8,  9,  64'h1A5,         32'hA5,       32'h0,        32'hA5,       1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 6'd8,  0,  64'h0,           32'h0,        32'hFFFFFFFF, 32'h0,        1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 6'd0,  32, 64'hDEADBEEF,    32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 6'd8,  8,  64'h3C,          32'h00,       32'hFFFFFFFF, 32'h3C,       1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 6'd40, 32, 64'h12345678,    32'h12345678, 32'h0,        32'h12345678, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 6'd8,  7,  64'h55,          32'h0,        32'h0,        32'hAA,       1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 6'd8,  8,  64'h5A,          32'hFFFFFF5A, 32'h0,        32'h5A,       1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 6'd32, 33, 64'h1_0000_0002, 32'h0,        32'h0,        32'h80000001, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 6'd8,  40, 64'hAB,          32'hAB,       32'h0,        32'hAB,       1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 6'd5,  5,  64'h13,          32'h13,       32'h0,        32'h13,       1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset SPItrig", 32'(SPItrig), 32'h0);
        chk("reset rx_vld", 32'(rx_vld), 32'h0);
        chk("reset frame_err", 32'(frame_err), 32'h0);
        chk("reset rx_data", rx_data, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            run_frame($sformatf("vec%0d", i), tbl[i].e, tbl[i].l, tbl[i].ln, tbl[i].n, tbl[i].d,
                      tbl[i].mt, tbl[i].mk, tbl[i].xd, tbl[i].xe, tbl[i].xt);
        end

        // Back-to-back frames with the minimum SS_n high time
        setup(1'b1, 1'b0, 6'd8, 32'hA5, 32'h0);
        send_bits(1'b0, 64'hA5, 8);
        end_frame(r1);
        @(negedge clk);
        send_bits(1'b0, 64'h5A, 8);
        end_frame(r2);
        check_result("b2b first", r1, 32'hA5, 1'b0, 1'b1);
        check_result("b2b second", r2, 32'h5A, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // Reset in the middle of a frame
        setup(1'b1, 1'b0, 6'd0, 32'hDEADBEEF, 32'h0);
        send_bits(1'b0, 64'hDEA, 12);
        rst_n = 1'b0;
        #1;
        chk("midrst SPItrig", 32'(SPItrig), 32'h0);
        chk("midrst rx_vld", 32'(rx_vld), 32'h0);
        chk("midrst frame_err", 32'(frame_err), 32'h0);
        chk("midrst rx_data", rx_data, 32'h0);
        @(negedge clk);
        SS_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        v0 = vld_count;
        repeat (20) @(negedge clk);
        chk("midrst no pulse", 32'(vld_count), 32'(v0));
        run_frame("after rst", 1'b1, 1'b0, 6'd0, 32, 64'hDEADBEEF, 32'hDEADBEEF, 32'h0,
                  32'hDEADBEEF, 1'b0, 1'b1);

        for (int i = 0; i < 30; i++) begin
            e   = 1'($urandom_range(0, 1));
            l   = 1'($urandom_range(0, 1));
            ln  = $urandom_range(0, 40);
            le  = (ln == 0 || ln > DW) ? DW : ln;
            sel = $urandom_range(0, 9);
            if (sel < 7) n = le;
            else if (sel == 7) n = le - 1;
            else if (sel == 8) n = le + 1;
            else n = $urandom_range(0, 3);
            d = {$urandom, $urandom};
            model_frame(l, ln, n, d, 32'h0, 32'h0, xd, xe, xt);
            sel = $urandom_range(0, 2);
            if (sel == 0) mt = xd;
            else if (sel == 1) mt = xd ^ (32'h1 << $urandom_range(0, le - 1));
            else mt = $urandom;
            mk = ($urandom_range(0, 1) == 0) ? 32'h0 : ($urandom & $urandom & $urandom);
            model_frame(l, ln, n, d, mt, mk, xd, xe, xt);
            run_frame($sformatf("rand%0d", i), e, l, LW'(ln), n, d, mt, mk, xd, xe, xt);
        end

`ifdef SPI_RX_TRIG_CNT_EN
        @(negedge clk);
        trig_cnt_clr = 1'b1;
        @(negedge clk);
        trig_cnt_clr = 1'b0;
        chk("cnt cleared", 32'(trig_cnt), 32'h0);
        for (int i = 0; i < 3; i++) begin
            run_frame($sformatf("cnt%0d", i), 1'b1, 1'b0, 6'd8, 8, 64'hA5, 32'hA5, 32'h0,
                      32'hA5, 1'b0, 1'b1);
        end
        chk("cnt three", 32'(trig_cnt), 32'h3);
        setup(1'b1, 1'b0, 6'd8, 32'hA5, 32'h0);
        send_bits(1'b0, 64'hA5, 8);
        end_frame(r1);
        while (cyc < r1 + SS + 2) @(negedge clk);
        trig_cnt_clr = 1'b1;
        chk("cnt clr with trig", 32'(SPItrig), 32'h1);
        @(negedge clk);
        trig_cnt_clr = 1'b0;
        check_result("cnt4", r1, 32'hA5, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        chk("cnt clr wins", 32'(trig_cnt), 32'h0);
`endif

        chk("pulse width", 32'(long_pulse), 32'h0);
        chk("stray pulses", 32'(stray), 32'h0);
        chk("queue empty", 32'(resq.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
